lram_write_sequencer: RTL

// Sequences all writes into the Maria line RAM for one scanline. It accepts display-list

---
 rtl/lram_write_sequencer_if.sv | 45 ++++
 rtl/lram_write_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lram_write_sequencer_if.sv
// DMA-side header/byte handshakes plus the line_ram strobe bundle driven by lram_write_sequencer.
interface lram_write_sequencer_if;
  logic       hdr_valid;
  logic       hdr_ready;
  logic [7:0] hdr_hpos;
  logic [2:0] hdr_palette;
  logic       hdr_wm;
  logic [4:0] hdr_width;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_data;
  logic       line_end;
  logic [7:0] lram_input_addr;
  logic [2:0] lram_palette;
  logic       lram_wm;
  logic       lram_input_w;
  logic       lram_palette_w;
  logic       lram_wm_w;
  logic [7:0] lram_pixels;
  logic       lram_pixels_w;
  logic       lram_swap;
  logic       obj_done;
  logic       truncated;
  logic       busy;

  modport master (
    output hdr_valid, hdr_hpos, hdr_palette, hdr_wm, hdr_width,
    output pix_valid, pix_data, line_end,
    input  hdr_ready, pix_ready,
    input  lram_input_addr, lram_palette, lram_wm,
    input  lram_input_w, lram_palette_w, lram_wm_w,
    input  lram_pixels, lram_pixels_w, lram_swap,
    input  obj_done, truncated, busy
  );

  modport slave (
    input  hdr_valid, hdr_hpos, hdr_palette, hdr_wm, hdr_width,
    input  pix_valid, pix_data, line_end,
    output hdr_ready, pix_ready,
    output lram_input_addr, lram_palette, lram_wm,
    output lram_input_w, lram_palette_w, lram_wm_w,
    output lram_pixels, lram_pixels_w, lram_swap,
    output obj_done, truncated, busy
  );
endinterface

// File: rtl/lram_write_sequencer.sv
// Turns DMA object headers and graphics bytes into line_ram setup/pixel strobes for one scanline,
// and issues the end-of-line buffer swap only in cycles free of pixel writes.
module lram_write_sequencer #(
  parameter int unsigned BYTE_GAP = 0
) (
  input logic                   SYSCLK,
  input logic                   RESET,
  lram_write_sequencer_if.slave bus
);
  localparam int unsigned CNT_W = 6;
  localparam int unsigned GAP_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    SWAP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             swap_pend, swap_pend_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [GAP_W-1:0] gap, gap_nxt;

  logic hdr_ready_c, pix_ready_c, busy_c;
  logic hdr_hs, pix_hs;
  logic setup_w_nxt, pixels_w_nxt, obj_done_nxt, truncated_nxt;

  logic [7:0] input_addr_q;
  logic [2:0] palette_q;
  logic       wm_q;
  logic       setup_w_q;
  logic [7:0] pixels_q;
  logic       pixels_w_q;
  logic       swap_q;
  logic       obj_done_q;
  logic       truncated_q;

  // A LINE_END in IDLE wins over a header offered in the same cycle.
  assign hdr_ready_c = (state == IDLE) && !swap_pend && !bus.line_end && !RESET;
  assign pix_ready_c = (state == STREAM) && (gap == GAP_W'(0)) && !RESET;
  assign busy_c      = (state != IDLE) && !RESET;
  assign hdr_hs      = bus.hdr_valid && hdr_ready_c;
  assign pix_hs      = bus.pix_valid && pix_ready_c;

  always_comb begin
    state_nxt     = state;
    swap_pend_nxt = swap_pend | bus.line_end;
    count_nxt     = count;
    gap_nxt       = gap;
    setup_w_nxt   = 1'b0;
    pixels_w_nxt  = 1'b0;
    obj_done_nxt  = 1'b0;
    truncated_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (swap_pend || bus.line_end) begin
          state_nxt = SWAP;
        end else if (hdr_hs) begin
          state_nxt   = SETUP;
          count_nxt   = (bus.hdr_width == 5'd0) ? CNT_W'(32) : CNT_W'(bus.hdr_width);
          gap_nxt     = GAP_W'(0);
          setup_w_nxt = 1'b1;
        end
      end
      SETUP: begin
        if (bus.line_end) begin
          state_nxt     = FLUSH;
          truncated_nxt = 1'b1;
        end else begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (pix_hs) begin
          pixels_w_nxt = 1'b1;
          count_nxt    = count - CNT_W'(1);
          gap_nxt      = GAP_W'(BYTE_GAP);
        end else if (gap != GAP_W'(0)) begin
          gap_nxt = gap - GAP_W'(1);
        end
        // The last byte completes normally even if LINE_END arrives with it.
        if (pix_hs && (count == CNT_W'(1))) begin
          state_nxt    = IDLE;
          obj_done_nxt = 1'b1;
        end else if (bus.line_end) begin
          state_nxt     = FLUSH;
          truncated_nxt = 1'b1;
        end
      end
      FLUSH: state_nxt = SWAP;
      SWAP: begin
        state_nxt     = IDLE;
        swap_pend_nxt = bus.line_end;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state        <= IDLE;
      swap_pend    <= 1'b0;
      count        <= '0;
      gap          <= '0;
      input_addr_q <= '0;
      palette_q    <= '0;
      wm_q         <= 1'b0;
      setup_w_q    <= 1'b0;
      pixels_q     <= '0;
      pixels_w_q   <= 1'b0;
      swap_q       <= 1'b0;
      obj_done_q   <= 1'b0;
      truncated_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      swap_pend   <= swap_pend_nxt;
      count       <= count_nxt;
      gap         <= gap_nxt;
      setup_w_q   <= setup_w_nxt;
      pixels_w_q  <= pixels_w_nxt;
      swap_q      <= (state_nxt == SWAP);
      obj_done_q  <= obj_done_nxt;
      truncated_q <= truncated_nxt;
      if (hdr_hs) begin
        input_addr_q <= bus.hdr_hpos;
        palette_q    <= bus.hdr_palette;
        wm_q         <= bus.hdr_wm;
      end
      if (pix_hs) begin
        pixels_q <= bus.pix_data;
      end
    end
  end

  assign bus.hdr_ready       = hdr_ready_c;
  assign bus.pix_ready       = pix_ready_c;
  assign bus.busy            = busy_c;
  assign bus.lram_input_addr = input_addr_q;
  assign bus.lram_palette    = palette_q;
  assign bus.lram_wm         = wm_q;
  assign bus.lram_input_w    = setup_w_q;
  assign bus.lram_palette_w  = setup_w_q;
  assign bus.lram_wm_w       = setup_w_q;
  assign bus.lram_pixels     = pixels_q;
  assign bus.lram_pixels_w   = pixels_w_q;
  assign bus.lram_swap       = swap_q;
  assign bus.obj_done        = obj_done_q;
  assign bus.truncated       = truncated_q;
endmodule
